// File: rtl/mips_pkg.sv
// mips_pkg
//   Shared types and constants for the MIPS memory subsystem.
//   - arb_state_t : arbiter FSM states
//   - arb_owner_t : which requester currently owns the memory port
//   - MIPS_MEM_TIMEOUT : default stall limit, also used by the memory model
//   - pick_owner  : round-robin grant decision
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    INSTR = 1'b0,
    DATA  = 1'b1
  } arb_owner_t;

  localparam int MIPS_MEM_TIMEOUT = 255;

  // With both requesters pending, the one that did not win last time is
  // granted, so a stage that keeps requesting can never lock out the other.
  function automatic arb_owner_t pick_owner(input logic       i_pend,
                                            input logic       d_pend,
                                            input arb_owner_t last);
    arb_owner_t win;
    if (i_pend && d_pend) begin
      win = (last == INSTR) ? DATA : INSTR;
    end else if (d_pend) begin
      win = DATA;
    end else begin
      win = INSTR;
    end
    return win;
  endfunction

endpackage

// File: rtl/mips_arb_timer.sv
// mips_arb_timer
//   Loadable up-counter used to bound how long the arbiter waits on memory.
//   Ports:
//     clk, rst      clock, asynchronous active-low reset
//     clr           synchronous clear to 0 (highest priority)
//     load/load_val synchronous load
//     en            count up by one; saturates at TIMEOUT so it never wraps
//     count         current value
//     expire        high while count == TIMEOUT-1 (last allowed wait cycle)
module mips_arb_timer
  import mips_pkg::*;
#(
  parameter int TIMEOUT = MIPS_MEM_TIMEOUT,
  localparam int TW     = $clog2(TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic [TW-1:0] count,
  output logic          expire
);

  localparam logic [TW-1:0] MAX_VAL  = TW'(TIMEOUT);
  localparam logic [TW-1:0] LAST_VAL = TW'(TIMEOUT - 1);

  logic [TW-1:0] count_q;

  // Counter register; holds at MAX_VAL instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && (count_q != MAX_VAL)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count  = count_q;
  assign expire = (count_q == LAST_VAL);

endmodule

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter
//   Shares one single-port memory between instruction fetch (i_*) and
//   load/store (d_*) using round-robin arbitration, and aborts accesses that
//   stall for TIMEOUT cycles, reporting them through i_err/d_err.
//   Ports:
//     clk, rst                 clock, asynchronous active-low reset
//     i_req/i_addr             fetch request (held until i_ack)
//     i_rdata/i_ack/i_err      fetch response, ack is a one-cycle pulse
//     d_req/d_we/d_be/d_addr/d_wdata  load/store request (held until d_ack)
//     d_rdata/d_ack/d_err      load/store response, ack is a one-cycle pulse
//     m_req/m_we/m_be/m_addr/m_wdata  memory request side
//     m_rdata/m_ack            memory response, ack is a one-cycle pulse
module mips_mem_arbiter
  import mips_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = MIPS_MEM_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              d_err,
  output logic              m_req,
  output logic              m_we,
  output logic [3:0]        m_be,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack
);

  localparam int TW = $clog2(TIMEOUT + 1);

  arb_state_t        state_q, state_n;
  arb_owner_t        owner_q, owner_n;
  arb_owner_t        last_q, last_n;
  logic              we_q, we_n;
  logic [3:0]        be_q, be_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [DATA_W-1:0] wdata_q, wdata_n;
  logic [DATA_W-1:0] irdata_q, irdata_n;
  logic [DATA_W-1:0] drdata_q, drdata_n;
  logic              err_q, err_n;

  logic              tmr_clr;
  logic              tmr_en;
  logic              tmr_expire;
  logic [TW-1:0]     tmr_count;

  // The timer is held at zero outside BUSY so every access starts with a
  // full wait budget, and counts only while memory is being waited on.
  mips_arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (tmr_clr),
    .en       (tmr_en),
    .load     (1'b0),
    .load_val ('0),
    .count    (tmr_count),
    .expire   (tmr_expire)
  );

  // State and captured-request registers. Resetting state here is what
  // makes m_req drop immediately when rst falls mid-access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      owner_q  <= INSTR;
      last_q   <= INSTR;
      we_q     <= 1'b0;
      be_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      irdata_q <= '0;
      drdata_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_n;
      owner_q  <= owner_n;
      last_q   <= last_n;
      we_q     <= we_n;
      be_q     <= be_n;
      addr_q   <= addr_n;
      wdata_q  <= wdata_n;
      irdata_q <= irdata_n;
      drdata_q <= drdata_n;
      err_q    <= err_n;
    end
  end

  // Next-state logic. The winning request is captured on grant so that a
  // requester changing its fields mid-access cannot corrupt the memory cycle.
  // An m_ack in the timeout cycle wins over the abort.
  always_comb begin
    state_n  = state_q;
    owner_n  = owner_q;
    last_n   = last_q;
    we_n     = we_q;
    be_n     = be_q;
    addr_n   = addr_q;
    wdata_n  = wdata_q;
    irdata_n = irdata_q;
    drdata_n = drdata_q;
    err_n    = err_q;
    tmr_clr  = 1'b0;
    tmr_en   = 1'b0;

    unique case (state_q)
      IDLE: begin
        tmr_clr = 1'b1;
        if (i_req || d_req) begin
          owner_n = pick_owner(i_req, d_req, last_q);
          last_n  = owner_n;
          state_n = BUSY;
          if (owner_n == DATA) begin
            we_n    = d_we;
            be_n    = d_be;
            addr_n  = d_addr;
            wdata_n = d_wdata;
          end else begin
            we_n    = 1'b0;
            be_n    = 4'hF;
            addr_n  = i_addr;
            wdata_n = '0;
          end
        end
      end

      BUSY: begin
        tmr_en = 1'b1;
        if (m_ack) begin
          err_n   = 1'b0;
          state_n = RESP;
          if (owner_q == DATA) begin
            drdata_n = m_rdata;
          end else begin
            irdata_n = m_rdata;
          end
        end else if (tmr_expire) begin
          err_n   = 1'b1;
          state_n = RESP;
          if (owner_q == DATA) begin
            drdata_n = '0;
          end else begin
            irdata_n = '0;
          end
        end
      end

      RESP: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign m_req   = (state_q == BUSY);
  assign m_we    = we_q;
  assign m_be    = be_q;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;

  assign i_ack   = (state_q == RESP) && (owner_q == INSTR);
  assign d_ack   = (state_q == RESP) && (owner_q == DATA);
  assign i_err   = i_ack && err_q;
  assign d_err   = d_ack && err_q;
  assign i_rdata = irdata_q;
  assign d_rdata = drdata_q;

endmodule

// File: doc/mips_mem_arbiter.md
Name: mips_mem_arbiter

Overview:
- Two-requester arbiter that shares one unified single-port memory between the MIPS instruction-fetch stage and the load/store stage.
- Serialises accesses with a request/ack handshake on each side and uses round-robin fairness so neither stage can starve the other.
- Aborts any memory access that stalls past a cycle limit and reports it as an error to the requester.
- Sits between the cpu core and the memory model, inside the mips top level.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data word width.
- TIMEOUT, 255, maximum cycles to wait for m_ack before aborting; legal range 1..65535.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-low: rst=0 resets immediately, release is synchronous to clk.
- i_req  in  1  fetch request; held high until i_ack.
- i_addr  in  ADDR_W  fetch address; stable while i_req=1.
- i_rdata  out  DATA_W  fetch data; valid when i_ack=1.
- i_ack  out  1  one-cycle completion pulse.
- i_err  out  1  qualifies i_ack: access timed out.
- d_req  in  1  data request; held high until d_ack.
- d_we  in  1  1=store, 0=load.
- d_be  in  4  byte enables for a store.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data; valid when d_ack=1.
- d_ack  out  1  one-cycle completion pulse.
- d_err  out  1  qualifies d_ack: access timed out.
- m_req  out  1  memory request; held until m_ack or abort.
- m_we  out  1  memory write enable.
- m_be  out  4  memory byte enables.
- m_addr  out  ADDR_W  memory address.
- m_wdata  out  DATA_W  memory write data.
- m_rdata  in  DATA_W  memory read data; valid with m_ack.
- m_ack  in  1  memory completion; single-cycle pulse.

Behaviour:
- Reset (rst=0):
  - state=IDLE, last_grant=INSTR, timer=0.
  - All outputs 0, including rdata buses.
  - Reset takes effect mid-transaction: m_req drops asynchronously and the in-flight access is discarded with no ack.
- States:
  - IDLE -> BUSY when any request is pending.
  - BUSY -> RESP on m_ack or on timeout.
  - RESP -> IDLE unconditionally.
- IDLE, arbitration:
  - Only one requester pending: grant it.
  - Both pending: grant the requester not in last_grant.
  - On grant: capture owner, we, be, addr and wdata into registers; m_* outputs are driven from these registers.
  - For a fetch grant: m_we=0, m_be=4'hF.
  - Update last_grant; timer=0.
- BUSY:
  - m_req=1; timer increments each cycle.
  - m_ack=1: latch m_rdata into the owner's rdata register, err=0, m_req=0, go to RESP.
  - timer==TIMEOUT-1 with no m_ack: m_req=0, owner rdata=0, err=1, go to RESP.
  - m_ack in the same cycle as the timeout: treated as a normal completion, err=0.
  - m_ack while IDLE or RESP is ignored.
- RESP:
  - Owner's ack=1 and err as latched, for exactly one cycle.
  - The non-owner's ack and err stay 0.
  - rdata holds its value until the next completion for that port.
- Latency:
  - Request visible at IDLE edge N gives m_req high from N+1.
  - m_ack at edge M gives requester ack in cycle M+1.
  - Minimum occupancy is 3 cycles per access (IDLE, BUSY, RESP) with zero-wait memory that acks in the first BUSY cycle.
- Requester contract:
  - req and its fields stay stable until ack.
  - In the cycle after ack, req reflects the next request; the next IDLE cycle re-arbitrates.
  - Captured fields make mid-access changes harmless; such changes are a protocol violation, and the transaction completes with the captured values.
- Stores: the ack carries rdata = whatever m_rdata held at m_ack; the requester ignores it.
- timer width: clog2(TIMEOUT+1) bits; it never wraps.

Decomposition:
- mips_pkg holds:
  - typedef enum {IDLE, BUSY, RESP} arb_state_t;
  - typedef enum {INSTR, DATA} arb_owner_t;
  - a default TIMEOUT localparam shared with the memory model.
- Sub-module mips_arb_timer: a loadable up-counter with clear, enable and expire outputs, parameterised by TIMEOUT. The arbiter FSM instantiates it.

Test Plan:
- Reset: hold rst=0 for 2 cycles with i_req=d_req=1 -> all outputs 0, m_req stays 0; after release m_req rises within 2 cycles.
- Fetch only:
  - Stimulus: i_req=1, i_addr=32'h0000_0040; memory acks after 3 BUSY cycles with 32'h2008_0005.
  - Response: m_addr=32'h40, m_we=0, m_be=4'hF; i_ack pulses once with i_rdata=32'h2008_0005.
- Contention:
  - Stimulus: i_req and d_req high together on consecutive requests, last_grant=INSTR after reset.
  - Response: grant order DATA, INSTR, DATA, INSTR; each ack is a single pulse; no requester waits more than one other access.
- Store:
  - Stimulus: d_req=1, d_we=1, d_be=4'b0011, d_addr=32'h100, d_wdata=32'hCAFE_BABE.
  - Response: m_we=1, m_be=4'b0011, m_wdata=32'hCAFE_BABE; d_ack=1, d_err=0.
- Timeout:
  - Stimulus: TIMEOUT=8, memory never acks a load to 32'h200.
  - Response: m_req high for exactly 8 cycles, then d_ack=1, d_err=1, d_rdata=0; a following fetch completes normally.
- Mid-transaction reset: assert rst=0 during BUSY -> m_req drops the same cycle, no ack is issued; after release a fresh fetch to 32'h0 completes correctly.
